// File: rtl/l1_cache_ctrl_if.sv
// CPU-side and L2-side signal bundle for the direct-mapped L1 cache controller.
// The cache uses the slave modport; the CPU/L2 environment uses the master modport.
interface l1_cache_ctrl_if;
    // CPU side
    logic        ivalid;
    logic        iRW;
    logic [10:0] iaddress;
    logic [7:0]  iwrite_data;
    logic        oready;
    logic [7:0]  oread_data;
    logic        oL1miss;
    // L2 side
    logic        oL2_req;
    logic        oL2_RW;
    logic [10:0] oL2_address;
    logic [7:0]  oL2_write_data;
    logic        iL2_ready;
    logic [31:0] iL2_read_data;

    modport slave (
        input  ivalid, iRW, iaddress, iwrite_data, iL2_ready, iL2_read_data,
        output oready, oread_data, oL1miss,
        output oL2_req, oL2_RW, oL2_address, oL2_write_data
    );

    modport master (
        output ivalid, iRW, iaddress, iwrite_data, iL2_ready, iL2_read_data,
        input  oready, oread_data, oL1miss,
        input  oL2_req, oL2_RW, oL2_address, oL2_write_data
    );
endinterface

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 cache controller.
// One request at a time: IDLE -> LOOKUP -> (REFILL | WRITE_WAIT) -> RESPOND -> IDLE.
module l1_cache_ctrl #(
    parameter int NUM_LINES   = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic           clk,
    input  logic           rst,
    l1_cache_ctrl_if.slave bus
);
    localparam int ADDR_W   = 11;
    localparam int INDEX_W  = $clog2(NUM_LINES);
    localparam int OFFSET_W = $clog2(BLOCK_BYTES);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        WRITE_WAIT,
        RESPOND
    } state_t;

    typedef logic [BLOCK_BYTES-1:0][7:0] block_t;

    state_t state;
    state_t next_state;

    // Latched request
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_wdata;
    logic              miss_flag;
    logic [7:0]        resp_data;

    // Cache storage
    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_array  [NUM_LINES];
    block_t               data_array [NUM_LINES];

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_offset;
    logic                hit;
    logic                refill_done;
    logic                write_done;
    block_t              refill_block;

    assign req_tag      = req_addr[ADDR_W-1 -: TAG_W];
    assign req_index    = req_addr[OFFSET_W +: INDEX_W];
    assign req_offset   = req_addr[OFFSET_W-1:0];
    assign hit          = valid[req_index] && (tag_array[req_index] == req_tag);
    assign refill_block = bus.iL2_read_data;

    // L2 completion only counts in the two states that actually hold oL2_req high.
    assign refill_done  = (state == REFILL)     && bus.iL2_ready;
    assign write_done   = (state == WRITE_WAIT) && bus.iL2_ready;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (bus.ivalid) next_state = LOOKUP;
            LOOKUP: begin
                if (!req_rw)  next_state = WRITE_WAIT;
                else if (hit) next_state = RESPOND;
                else          next_state = REFILL;
            end
            REFILL:     if (bus.iL2_ready) next_state = RESPOND;
            WRITE_WAIT: if (bus.iL2_ready) next_state = RESPOND;
            RESPOND:    next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    // Outputs are decoded from state and reset registers only, so reset clears them at once.
    always_comb begin
        bus.oready         = 1'b0;
        bus.oread_data     = '0;
        bus.oL1miss        = 1'b0;
        bus.oL2_req        = 1'b0;
        bus.oL2_RW         = 1'b0;
        bus.oL2_address    = '0;
        bus.oL2_write_data = '0;
        case (state)
            REFILL: begin
                bus.oL1miss     = 1'b1;
                bus.oL2_req     = 1'b1;
                bus.oL2_RW      = 1'b1;
                bus.oL2_address = {req_tag, req_index, {OFFSET_W{1'b0}}};
            end
            WRITE_WAIT: begin
                bus.oL1miss        = miss_flag;
                bus.oL2_req        = 1'b1;
                bus.oL2_RW         = 1'b0;
                bus.oL2_address    = req_addr;
                bus.oL2_write_data = req_wdata;
            end
            RESPOND: begin
                bus.oready     = 1'b1;
                bus.oread_data = resp_data;
                bus.oL1miss    = miss_flag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_rw    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            miss_flag <= 1'b0;
            resp_data <= '0;
            valid     <= '0;
        end else begin
            if (state == IDLE && bus.ivalid) begin
                req_rw    <= bus.iRW;
                req_addr  <= bus.iaddress;
                req_wdata <= bus.iwrite_data;
            end
            if (state == LOOKUP) begin
                miss_flag <= !hit;
                if (req_rw && hit) resp_data <= data_array[req_index][req_offset];
            end
            if (refill_done) begin
                resp_data        <= refill_block[req_offset];
                valid[req_index] <= 1'b1;
            end
            if (write_done) resp_data <= '0;
        end
    end

    // NOTE: tag and data storage carry no reset; the valid bits alone decide
    // whether their contents mean anything, which keeps these plain RAM.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            tag_array[req_index]  <= req_tag;
            data_array[req_index] <= refill_block;
        end else if (state == LOOKUP && !req_rw && hit) begin
            data_array[req_index][req_offset] <= req_wdata;
        end
    end
endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Self-checking bench for l1_cache_ctrl: directed scenarios then random traffic,
// all predicted by a line-level cache model kept in the bench.
module tb_l1_cache_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    l1_cache_ctrl_if bus ();

    l1_cache_ctrl #(.NUM_LINES(8), .BLOCK_BYTES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: one entry per line, bytes stored individually
    bit         m_valid [8];
    logic [5:0] m_tag   [8];
    logic [7:0] m_data  [8][4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_oready"},   32'(bus.oready),         32'h0);
        chk({tag, "_rdata"},    32'(bus.oread_data),     32'h0);
        chk({tag, "_miss"},     32'(bus.oL1miss),        32'h0);
        chk({tag, "_l2req"},    32'(bus.oL2_req),        32'h0);
        chk({tag, "_l2rw"},     32'(bus.oL2_RW),         32'h0);
        chk({tag, "_l2addr"},   32'(bus.oL2_address),    32'h0);
        chk({tag, "_l2wdata"},  32'(bus.oL2_write_data), 32'h0);
    endtask

    // Caller is at a negedge inside an IDLE cycle; returns at a negedge inside the next IDLE cycle.
    task automatic txn(input bit rw, input logic [10:0] addr, input logic [7:0] wd,
                       input int w, input logic [31:0] blk, input bit hold,
                       output logic [7:0] rd);
        int          idx, off, cyc, n_req, exp_lat, exp_req;
        bit          hit, done;
        logic [10:0] exp_addr;
        logic [7:0]  exp_data;

        idx = int'(addr[4:2]);
        off = int'(addr[1:0]);
        hit = m_valid[idx] && (m_tag[idx] == addr[10:5]);
        exp_req  = (rw && hit) ? 0 : w + 1;
        exp_lat  = (rw && hit) ? 2 : 3 + w;
        exp_addr = rw ? {addr[10:2], 2'b00} : addr;
        exp_data = !rw ? 8'h00 : (hit ? m_data[idx][off] : blk[8*off +: 8]);
        if (rw && !hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = addr[10:5];
            for (int b = 0; b < 4; b++) m_data[idx][b] = blk[8*b +: 8];
        end
        if (!rw && hit) m_data[idx][off] = wd;

        bus.ivalid      = 1'b1;
        bus.iRW         = rw;
        bus.iaddress    = addr;
        bus.iwrite_data = wd;
        cyc   = 0;
        n_req = 0;
        done  = 1'b0;
        rd    = 8'hxx;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (!hold) begin
                // Request fields were latched; scramble them to expose any re-sampling.
                bus.ivalid      = 1'b0;
                bus.iRW         = 1'($urandom);
                bus.iaddress    = 11'($urandom);
                bus.iwrite_data = 8'($urandom);
            end
            if (bus.oready) begin
                done = 1'b1;
                rd   = bus.oread_data;
                chk("latency", 32'(cyc), 32'(exp_lat));
                chk("rdata", 32'(bus.oread_data), 32'(exp_data));
                chk("resp_miss", 32'(bus.oL1miss), 32'(!hit));
                chk("resp_l2req", 32'(bus.oL2_req), 32'h0);
                bus.iL2_ready     = 1'b0;
                bus.iL2_read_data = $urandom;
            end else if (bus.oL2_req) begin
                n_req++;
                chk("l2_rw", 32'(bus.oL2_RW), 32'(rw));
                chk("l2_addr", 32'(bus.oL2_address), 32'(exp_addr));
                if (!rw) chk("l2_wdata", 32'(bus.oL2_write_data), 32'(wd));
                chk("l2_miss", 32'(bus.oL1miss), 32'(!hit));
                bus.iL2_ready     = (n_req == w + 1);
                bus.iL2_read_data = (n_req == w + 1) ? blk : $urandom;
            end else begin
                chk("lookup_miss", 32'(bus.oL1miss), 32'h0);
                // Ready without a pending request must be ignored.
                bus.iL2_ready     = 1'($urandom_range(0, 1));
                bus.iL2_read_data = $urandom;
            end
        end
        if (!done) chk("oready_timeout", 32'h0, 32'h1);
        chk("l2_req_cycles", 32'(n_req), 32'(exp_req));
        bus.iL2_ready = 1'b0;
        bus.ivalid    = hold;
        @(negedge clk);
        chk("idle_oready", 32'(bus.oready), 32'h0);
        chk("idle_l2req", 32'(bus.oL2_req), 32'h0);
        chk("idle_miss", 32'(bus.oL1miss), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rd;
        bus.ivalid        = 1'b0;
        bus.iRW           = 1'b0;
        bus.iaddress      = '0;
        bus.iwrite_data   = '0;
        bus.iL2_ready     = 1'b0;
        bus.iL2_read_data = '0;
        model_clear();

        rst = 1'b1;
        #1;
        chk_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_outputs_zero("post_reset");

        // Cold read miss, then a hit on the same line
        txn(1'b1, 11'h0A5, 8'h00, 3, 32'h44332211, 1'b0, rd);
        chk("cold_read", 32'(rd), 32'h22);
        txn(1'b1, 11'h0A6, 8'h00, 0, 32'h0, 1'b0, rd);
        chk("read_hit", 32'(rd), 32'h33);

        // Conflicting tag on index 1 evicts, original line misses again
        txn(1'b1, 11'h0E5, 8'h00, 1, 32'hDDCCBBAA, 1'b0, rd);
        chk("evict_read", 32'(rd), 32'hBB);
        txn(1'b1, 11'h0A5, 8'h00, 2, 32'h44332211, 1'b0, rd);
        chk("reread_after_evict", 32'(rd), 32'h22);

        // Write hit goes through to L2 and updates the line
        txn(1'b0, 11'h0A7, 8'h5A, 2, 32'h0, 1'b0, rd);
        chk("write_hit_rdata", 32'(rd), 32'h00);
        txn(1'b1, 11'h0A7, 8'h00, 0, 32'h0, 1'b0, rd);
        chk("read_after_write", 32'(rd), 32'h5A);

        // ivalid held through REFILL/RESPOND; the IDLE-cycle strobe is a new request
        txn(1'b1, 11'h0E5, 8'h00, 2, 32'hDDCCBBAA, 1'b1, rd);
        chk("hold_first", 32'(rd), 32'hBB);
        txn(1'b1, 11'h0E6, 8'h00, 0, 32'h0, 1'b0, rd);
        chk("hold_second_hit", 32'(rd), 32'hCC);

        // Reset in the middle of a refill
        bus.ivalid   = 1'b1;
        bus.iRW      = 1'b1;
        bus.iaddress = 11'h0A5;
        @(negedge clk);
        bus.ivalid = 1'b0;
        @(negedge clk);
        chk("mid_refill_req", 32'(bus.oL2_req), 32'h1);
        #2 rst = 1'b1;
        #1 chk_outputs_zero("async_reset");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        bus.iL2_ready     = 1'b1;
        bus.iL2_read_data = 32'h44332211;
        repeat (2) begin
            @(negedge clk);
            chk("stale_ready_l2req", 32'(bus.oL2_req), 32'h0);
            chk("stale_ready_oready", 32'(bus.oready), 32'h0);
        end
        bus.iL2_ready = 1'b0;
        txn(1'b1, 11'h0A5, 8'h00, 0, 32'h11223344, 1'b0, rd);
        chk("reread_after_reset", 32'(rd), 32'h33);

        // Write miss on an empty cache leaves the line invalid
        rst = 1'b1;
        #1 model_clear();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        txn(1'b0, 11'h100, 8'h77, 1, 32'h0, 1'b0, rd);
        chk("write_miss_rdata", 32'(rd), 32'h00);
        txn(1'b1, 11'h100, 8'h00, 0, 32'h0C0B0A09, 1'b0, rd);
        chk("read_after_write_miss", 32'(rd), 32'h09);

        // Random traffic over a small tag pool so hits, misses and evictions all occur
        for (int n = 0; n < 150; n++) begin
            logic [10:0] a;
            a = {3'($urandom_range(0, 1)) + 3'd2, 3'($urandom), 3'($urandom), 2'($urandom)};
            txn(1'($urandom_range(0, 2) != 0), a, 8'($urandom), int'($urandom_range(0, 3)),
                $urandom, 1'b0, rd);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
